// File: rtl/spatz_boot_sequencer_if.sv
// Request/response link between the boot sequencer (master) and the reqrsp_to_axi bridge (slave).
// The parameters must match the AddrWidth/DataWidth of the sequencer that drives it.
interface spatz_boot_sequencer_if #(
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned DataWidth = 64
);

   logic [AddrWidth-1:0]   q_addr;
   logic [DataWidth-1:0]   q_data;
   logic                   q_write;
   logic [DataWidth/8-1:0] q_strb;
   logic                   q_valid;
   logic                   q_ready;
   logic [DataWidth-1:0]   p_data;
   logic                   p_error;
   logic                   p_valid;
   logic                   p_ready;

   modport master (
      output q_addr, q_data, q_write, q_strb, q_valid, p_ready,
      input  q_ready, p_data, p_error, p_valid
   );

   modport slave (
      input  q_addr, q_data, q_write, q_strb, q_valid, p_ready,
      output q_ready, p_data, p_error, p_valid
   );

endinterface

// File: rtl/spatz_boot_sequencer.sv
// Multi-cluster boot controller: writes the entry point into every cluster's BOOT_CONTROL register,
// then pulses debug_req to wake all cores. Define SPATZ_BOOT_READBACK_EN to verify each write by readback.
module spatz_boot_sequencer #(
   parameter int unsigned          NumClusters      = 1,
   parameter int unsigned          NumCores         = 2,
   parameter int unsigned          AddrWidth        = 48,
   parameter int unsigned          DataWidth        = 64,
   parameter logic [AddrWidth-1:0] PeriStartAddr    = '0,
   parameter logic [AddrWidth-1:0] ClusterStride    = AddrWidth'(32'h40000),
   parameter logic [AddrWidth-1:0] BootCtrlOffset   = '0,
   parameter int unsigned          WakeDelay        = 1000,
   parameter int unsigned          DebugPulseCycles = 1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                start_i,
   input  logic [31:0]                         entry_i,
   output logic                                busy_o,
   output logic                                done_o,
   output logic                                error_o,
   output logic [$clog2(NumClusters):0]        err_cluster_o,
   output logic [NumClusters*NumCores-1:0]     debug_req_o,
   spatz_boot_sequencer_if.master              bus
);

   localparam int unsigned ClW    = $clog2(NumClusters) + 1;
   localparam int unsigned MaxCnt = (WakeDelay > DebugPulseCycles) ? WakeDelay : DebugPulseCycles;
   localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

   localparam logic [ClW-1:0]  LastCluster = ClW'(NumClusters - 1);
   localparam logic [CntW-1:0] DelayLast   = CntW'(WakeDelay - 1);
   localparam logic [CntW-1:0] PulseLast   = CntW'(DebugPulseCycles - 1);

`ifdef SPATZ_BOOT_READBACK_EN
   typedef enum logic [3:0] {
      IDLE, DELAY, REQ, RESP, RDREQ, RDRESP, WAKE, DONE, ERROR
   } state_e;
`else
   typedef enum logic [3:0] {
      IDLE, DELAY, REQ, RESP, WAKE, DONE, ERROR
   } state_e;
`endif

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [ClW-1:0]         cluster_q, cluster_d;
   logic [31:0]            entry_q, entry_d;
   logic [ClW-1:0]         err_cluster_q, err_cluster_d;
   logic [AddrWidth-1:0]   q_addr_q, q_addr_d;
   logic [DataWidth-1:0]   q_data_q, q_data_d;
   logic [DataWidth/8-1:0] q_strb_q, q_strb_d;
   logic                   q_valid_q, q_valid_d;
   logic                   p_ready_q, p_ready_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic                   debug_q, debug_d;
   logic                   cluster_ok;
   logic                   is_req_d;
`ifdef SPATZ_BOOT_READBACK_EN
   logic                   q_write_q, q_write_d;
`endif

   // Only the low 32 bits of a readback carry the entry point; the rest is don't-care.
   logic unused_p_data;
   assign unused_p_data = ^bus.p_data;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cluster_d     = cluster_q;
      entry_d       = entry_q;
      err_cluster_d = err_cluster_q;
      cluster_ok    = 1'b0;

      unique case (state_q)
         IDLE, DONE, ERROR: begin
            if (start_i) begin
               entry_d       = entry_i;
               cluster_d     = '0;
               cnt_d         = '0;
               err_cluster_d = '0;
               state_d       = (WakeDelay == 0) ? REQ : DELAY;
            end
         end
         DELAY: begin
            if (cnt_q == DelayLast) begin
               cnt_d   = '0;
               state_d = REQ;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         REQ: begin
            if (q_valid_q && bus.q_ready) state_d = RESP;
         end
         RESP: begin
            if (bus.p_valid && p_ready_q) begin
               if (bus.p_error) begin
                  err_cluster_d = cluster_q;
                  state_d       = ERROR;
               end else begin
`ifdef SPATZ_BOOT_READBACK_EN
                  state_d = RDREQ;
`else
                  cluster_ok = 1'b1;
`endif
               end
            end
         end
`ifdef SPATZ_BOOT_READBACK_EN
         RDREQ: begin
            if (q_valid_q && bus.q_ready) state_d = RDRESP;
         end
         RDRESP: begin
            if (bus.p_valid && p_ready_q) begin
               if (bus.p_error || (bus.p_data[31:0] != entry_q)) begin
                  err_cluster_d = cluster_q;
                  state_d       = ERROR;
               end else begin
                  cluster_ok = 1'b1;
               end
            end
         end
`endif
         WAKE: begin
            if (cnt_q == PulseLast) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A cluster is finished once its last response came back clean: move on or wake everyone.
      if (cluster_ok) begin
         if (cluster_q == LastCluster) begin
            cnt_d   = '0;
            state_d = WAKE;
         end else begin
            cluster_d = cluster_q + 1'b1;
            state_d   = REQ;
         end
      end

      // Outputs are decoded from the next state so that every port comes straight from a flop.
`ifdef SPATZ_BOOT_READBACK_EN
      is_req_d  = (state_d == REQ) || (state_d == RDREQ);
      q_write_d = (state_d == REQ);
      p_ready_d = (state_d == RESP) || (state_d == RDRESP);
`else
      is_req_d  = (state_d == REQ);
      p_ready_d = (state_d == RESP);
`endif
      q_valid_d = is_req_d;
      q_addr_d  = is_req_d ? (PeriStartAddr + AddrWidth'(cluster_d) * ClusterStride + BootCtrlOffset)
                           : '0;
      q_data_d  = is_req_d ? DataWidth'(entry_d) : '0;
      q_strb_d  = is_req_d ? '1 : '0;
      busy_d    = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERROR));
      done_d    = (state_d == DONE);
      error_d   = (state_d == ERROR);
      debug_d   = (state_d == WAKE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         cluster_q     <= '0;
         entry_q       <= '0;
         err_cluster_q <= '0;
         q_addr_q      <= '0;
         q_data_q      <= '0;
         q_strb_q      <= '0;
         q_valid_q     <= 1'b0;
         p_ready_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         debug_q       <= 1'b0;
`ifdef SPATZ_BOOT_READBACK_EN
         q_write_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cluster_q     <= cluster_d;
         entry_q       <= entry_d;
         err_cluster_q <= err_cluster_d;
         q_addr_q      <= q_addr_d;
         q_data_q      <= q_data_d;
         q_strb_q      <= q_strb_d;
         q_valid_q     <= q_valid_d;
         p_ready_q     <= p_ready_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
         debug_q       <= debug_d;
`ifdef SPATZ_BOOT_READBACK_EN
         q_write_q     <= q_write_d;
`endif
      end
   end

   assign bus.q_addr    = q_addr_q;
   assign bus.q_data    = q_data_q;
   assign bus.q_strb    = q_strb_q;
   assign bus.q_valid   = q_valid_q;
   assign bus.p_ready   = p_ready_q;
`ifdef SPATZ_BOOT_READBACK_EN
   assign bus.q_write   = q_write_q;
`else
   assign bus.q_write   = 1'b1;
`endif
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign err_cluster_o = err_cluster_q;
   assign debug_req_o   = {(NumClusters*NumCores){debug_q}};

endmodule
